uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 receiver behind the echo path of the serial test design.
- Adds 5–9 data bits, optional parity, 1/2 stop bits, a runtime baud divisor and 16x oversampling with majority vote.
- Adds framing, parity, break and overrun reporting, a one-word valid/ready holding register and an RTS output.
- Sits between the board rx pin and the echo/command logic, single clock domain.

Parameters:
- DIV_W, 16, width of baud_div_i.
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- OSR, 16, oversample ticks per bit, 8 or 16.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- baud_div_i  in  DIV_W  oversample tick period minus 1, in clk_i cycles. Must be static while the receiver is not IDLE.
- rx_i  in  1  asynchronous serial input; idle level is 1.
- data_o  out  DATA_BITS  received word, LSB = first data bit.
- valid_o  out  1  data_o and the error flags are valid.
- ready_i  in  1  consumer accepts the word when valid_o and ready_i are both 1.
- frame_err_o  out  1  the held word had a 0 stop bit.
- parity_err_o  out  1  the held word had a bad parity bit; always 0 when PARITY=0.
- break_o  out  1  one-cycle pulse when a break is detected.
- overrun_o  out  1  one-cycle pulse when a word is dropped.
- rts_o  out  1  1 = able to receive; equals ~valid_o.

Behaviour:
- Reset values: data_o 0, valid_o 0, frame_err_o 0, parity_err_o 0, break_o 0, overrun_o 0, rts_o 1, synchroniser flops 1, FSM in IDLE, tick counter 0.
- Reset mid-frame discards the partial frame; no flag is raised.
- Synchroniser: 2 flops on rx_i, giving rx_s; 2-cycle latency.
- Tick generator: free-running counter 0..baud_div_i. It pulses tick for one cycle when the count equals baud_div_i, then wraps to 0.
- Bit timing: per bit, a tick counter s runs 0..OSR-1.
- Sampling: rx_s is sampled on ticks s = OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the 3 samples, resolved at s = OSR/2+1.
- IDLE: a tick with rx_s = 0 enters START and sets s = 0.
- START: if the majority is 1, this is a false start; return to IDLE with no flags. Otherwise, at s = OSR-1, go to DATA.
- DATA: shift in DATA_BITS bits, LSB first. At the end of the last bit, go to PARITY if PARITY != 0, else STOP.
- PARITY: capture the bit. parity_err = captured bit XOR expected (even: XOR of data; odd: inverted XOR of data).
- STOP: each stop bit is voted. frame_err is set if any stop bit is 0. The frame completes at the vote of the last stop bit, not at the end of that bit, so back-to-back frames are supported.
- Break: on completion, data all 0, parity bit (if present) 0 and stop 0 together mean a break. break_o pulses, no word is delivered, and the FSM goes to WAIT_IDLE.
- Framing error (not a break): the word is delivered with frame_err_o = 1, then the FSM goes to WAIT_IDLE.
- WAIT_IDLE: leave for IDLE on the first tick with rx_s = 1.
- Clean frame: return to IDLE.
- Holding register: on completion, if it is empty or ready_i = 1 in the same cycle, it loads data and flags, and valid_o = 1 on the next cycle.
- Full register with ready_i = 0: the new word is dropped, the held word is unchanged, and overrun_o pulses.
- Transfer: valid_o & ready_i with no new word clears valid_o on the next cycle.
- Latency: valid_o rises 1 clk after the last stop-bit vote tick.

Decomposition:
- Package uart_pkg: PAR_NONE/PAR_EVEN/PAR_ODD constants; state encoding IDLE, START, DATA, PARITY, STOP, WAIT_IDLE; OSR default.
- Sub-module uart_baud_tick: divisor counter and tick output, reusable by a future transmitter.
- Synchroniser and FSM stay inline.

Test Plan:
- Defaults, 50 MHz clk_i, baud_div_i = 26 (115.7 kbaud), ready_i = 1, send 0x55 -> exactly one valid_o cycle, data_o = 0x55, all flags 0, rts_o drops for 1 cycle.
- Send 0xAA then 0x31 with no inter-frame gap -> two words in order, no overrun_o, no frame_err_o.
- ready_i = 0, send 0x12 then 0x34 -> data_o stays 0x12, rts_o = 0, overrun_o pulses once. After ready_i = 1: one transfer, rts_o = 1.
- Hold rx_i low for 86.8 µs, then high -> one break_o pulse, no valid_o. A following 0x5A is received cleanly.
- PARITY = 1 build, send 0x31 with parity bit 0 -> data_o 0x31, parity_err_o 1. With parity bit 1 -> parity_err_o 0.
- Robustness:
  - rx_i low for 3 ticks only -> nothing happens.
  - rst_i pulse in mid-frame -> no valid_o, outputs return to reset values. The next 0x55 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver and related blocks.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int OSR_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running counter 0..div_i, one-cycle tick at the top.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Tick when the count reaches the divisor, then wrap to zero.
    always_comb begin
        tick_o = (cnt_q == div_i);
        cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 16x/8x oversampling with 3-sample majority vote,
// optional parity, 1/2 stop bits, error reporting and a one-word holding register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1,
    parameter int OSR       = OSR_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_W-1:0]     baud_div_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic                 rts_o
);

    localparam int            SW        = $clog2(OSR);
    localparam logic [SW-1:0] S_V0      = SW'(OSR / 2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OSR / 2);
    localparam logic [SW-1:0] S_V2      = SW'(OSR / 2 + 1);
    localparam logic [SW-1:0] S_LAST    = SW'(OSR - 1);
    localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam bit            PAR_EN    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

    logic tick;

    uart_baud_tick #(
        .DIV_W(DIV_W)
    ) u_baud_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .div_i (baud_div_i),
        .tick_o(tick)
    );

    // Two-flop synchroniser on the asynchronous rx pin, idling high.
    logic sync1_q, sync2_q, rx_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 ferr_q, ferr_d;
    logic                 stop_one_q, stop_one_d;

    logic vote_bit, vote_now, s_last;
    logic ferr_any, one_any, par_exp;
    logic done, brk_det, new_fe, new_pe;

    assign vote_bit = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign vote_now = tick && (s_q == S_V2);
    assign s_last   = (s_q == S_LAST);
    assign ferr_any = ferr_q | ~vote_bit;
    assign one_any  = stop_one_q | vote_bit;
    assign par_exp  = (PARITY == PAR_ODD) ? ~(^shreg_q) : (^shreg_q);

    // Frame FSM next state: bit timing, sampling, shifting and completion detection.
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        ferr_d     = ferr_q;
        stop_one_d = stop_one_q;
        done       = 1'b0;
        brk_det    = 1'b0;
        new_fe     = ferr_any;
        new_pe     = PAR_EN && (par_bit_q ^ par_exp);

        if (tick) begin
            if (s_q == S_V0) samp_d[0] = rx_s;
            if (s_q == S_V1) samp_d[1] = rx_s;
            if (state_q != ST_IDLE && state_q != ST_WAIT_IDLE) begin
                s_d = s_last ? '0 : s_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        s_d     = '0;
                    end
                end
                ST_START: begin
                    if (vote_now && vote_bit) begin
                        state_d = ST_IDLE;
                        s_d     = '0;
                    end else if (s_last) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (vote_now) shreg_d = {vote_bit, shreg_q[DATA_BITS-1:1]};
                    if (s_last) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d    = PAR_EN ? ST_PARITY : ST_STOP;
                            stop_cnt_d = 1'b0;
                            ferr_d     = 1'b0;
                            stop_one_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_now) par_bit_d = vote_bit;
                    if (s_last) state_d = ST_STOP;
                end
                ST_STOP: begin
                    // Completion happens at the vote of the last stop bit so that a
                    // start edge arriving right after the stop bit is not missed.
                    if (vote_now && stop_cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        brk_det = (shreg_q == '0) && (!PAR_EN || !par_bit_q) && !one_any;
                        state_d = (brk_det || ferr_any) ? ST_WAIT_IDLE : ST_IDLE;
                        s_d     = '0;
                    end else begin
                        if (vote_now) begin
                            ferr_d     = ferr_any;
                            stop_one_d = one_any;
                        end
                        if (s_last) stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    s_d     = '0;
                end
            endcase
        end
    end

    // Frame FSM registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            samp_q     <= '1;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
            ferr_q     <= 1'b0;
            stop_one_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            par_bit_q  <= par_bit_d;
            ferr_q     <= ferr_d;
            stop_one_q <= stop_one_d;
        end
    end

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 pe_q, pe_d;
    logic                 brk_q, brk_d;
    logic                 ovr_q, ovr_d;

    // Holding register: load on completion when empty or being drained, else drop and flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = fe_q;
        pe_d    = pe_q;
        brk_d   = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && ready_i) valid_d = 1'b0;

        if (done) begin
            if (brk_det) begin
                brk_d = 1'b1;
            end else if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                fe_d    = new_fe;
                pe_d    = new_pe;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Holding register and pulse flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            brk_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            brk_q   <= brk_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = fe_q;
    assign parity_err_o = pe_q;
    assign break_o      = brk_q;
    assign overrun_o    = ovr_q;
    assign rts_o        = ~valid_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1 instance plus an even-parity instance.
module tb_uart_rx_param;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] baud    = 16'd26;
    logic        rx      = 1'b1;
    logic        rx_p    = 1'b1;
    logic        ready   = 1'b1;
    logic        ready_p = 1'b1;

    logic [7:0] data, data_p;
    logic       valid, fe, pe, brk, ovr, rts;
    logic       valid_p, fe_p, pe_p, brk_p, ovr_p, rts_p;

    int n_checks = 0;
    int n_err    = 0;

    always #10 clk = ~clk;

    uart_rx_param u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_div_i  (baud),
        .rx_i        (rx),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (fe),
        .parity_err_o(pe),
        .break_o     (brk),
        .overrun_o   (ovr),
        .rts_o       (rts)
    );

    uart_rx_param #(.PARITY(1)) u_dut_par (
        .clk_i       (clk),
        .rst_i       (rst),
        .baud_div_i  (baud),
        .rx_i        (rx_p),
        .data_o      (data_p),
        .valid_o     (valid_p),
        .ready_i     (ready_p),
        .frame_err_o (fe_p),
        .parity_err_o(pe_p),
        .break_o     (brk_p),
        .overrun_o   (ovr_p),
        .rts_o       (rts_p)
    );

    // Event monitors, sampled on the falling edge.
    int         valid_n = 0, rts_lo_n = 0, rts_bad_n = 0, ovr_n = 0, brk_n = 0, rx_n = 0;
    logic [9:0] rxw [64];
    int         p_rx_n = 0, p_evt_n = 0, p_rts_bad_n = 0;
    logic [9:0] p_rxw [8];
    int         rd = 0, p_rd = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) valid_n <= valid_n + 1;
            if (!rts) rts_lo_n <= rts_lo_n + 1;
            if (rts === valid) rts_bad_n <= rts_bad_n + 1;
            if (ovr) ovr_n <= ovr_n + 1;
            if (brk) brk_n <= brk_n + 1;
            if (valid && ready) begin
                rxw[rx_n % 64] <= {pe, fe, data};
                rx_n <= rx_n + 1;
            end
            if (brk_p || ovr_p) p_evt_n <= p_evt_n + 1;
            if (rts_p === valid_p) p_rts_bad_n <= p_rts_bad_n + 1;
            if (valid_p && ready_p) begin
                p_rxw[p_rx_n % 8] <= {pe_p, fe_p, data_p};
                p_rx_n <= p_rx_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int n);
        cyc(n * (int'(baud) + 1) * 16);
    endtask

    task automatic drive(input bit to_par, input logic v);
        if (to_par) rx_p = v;
        else        rx   = v;
    endtask

    task automatic send(input bit to_par, input logic [7:0] d, input bit with_par,
                        input logic pbit, input logic stopv);
        drive(to_par, 1'b0);
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(to_par, d[i]);
            wait_bits(1);
        end
        if (with_par) begin
            drive(to_par, pbit);
            wait_bits(1);
        end
        drive(to_par, stopv);
        wait_bits(1);
        drive(to_par, 1'b1);
    endtask

    task automatic expect_word(input string tag, input logic [7:0] d, input logic fe_e, input logic pe_e);
        logic [9:0] w;
        w = rxw[rd % 64];
        rd++;
        check({tag, "_data"}, w[7:0], d);
        check({tag, "_fe"}, w[8], fe_e);
        check({tag, "_pe"}, w[9], pe_e);
    endtask

    task automatic expect_pword(input string tag, input logic [7:0] d, input logic pe_e);
        logic [9:0] w;
        w = p_rxw[p_rd % 8];
        p_rd++;
        check({tag, "_data"}, w[7:0], d);
        check({tag, "_fe"}, w[8], 1'b0);
        check({tag, "_pe"}, w[9], pe_e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        int b_valid, b_rts, b_ovr, b_brk, b_rx, b_prx;

        // Reset values
        do_reset();
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_fe", fe, 1'b0);
        check("rst_pe", pe, 1'b0);
        check("rst_brk", brk, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_rts", rts, 1'b1);

        // 0x55 at divisor 26, consumer always ready
        b_valid = valid_n; b_rts = rts_lo_n; b_rx = rx_n;
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("t55_valid_cycles", valid_n - b_valid, 1);
        check("t55_rts_low_cycles", rts_lo_n - b_rts, 1);
        check("t55_words", rx_n - b_rx, 1);
        expect_word("t55", 8'h55, 1'b0, 1'b0);

        // Faster divisor for the remainder; changed under reset so the counter restarts
        baud = 16'd4;
        do_reset();

        // Back-to-back frames
        b_ovr = ovr_n; b_rx = rx_n;
        send(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h31, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("b2b_words", rx_n - b_rx, 2);
        check("b2b_ovr", ovr_n - b_ovr, 0);
        expect_word("b2b_0", 8'hAA, 1'b0, 1'b0);
        expect_word("b2b_1", 8'h31, 1'b0, 1'b0);

        // Overrun with consumer stalled
        ready = 1'b0;
        b_ovr = ovr_n; b_rx = rx_n;
        send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("ovr_data_held", data, 8'h12);
        check("ovr_valid", valid, 1'b1);
        check("ovr_rts", rts, 1'b0);
        check("ovr_pulses", ovr_n - b_ovr, 1);
        check("ovr_no_xfer", rx_n - b_rx, 0);
        ready = 1'b1;
        cyc(3);
        check("ovr_xfer_words", rx_n - b_rx, 1);
        expect_word("ovr", 8'h12, 1'b0, 1'b0);
        check("ovr_valid_clr", valid, 1'b0);
        check("ovr_rts_back", rts, 1'b1);

        // Break: line low for 12 bit times
        b_brk = brk_n; b_valid = valid_n; b_rx = rx_n;
        rx = 1'b0;
        wait_bits(12);
        rx = 1'b1;
        wait_bits(2);
        check("brk_pulses", brk_n - b_brk, 1);
        check("brk_no_valid", valid_n - b_valid, 0);
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("brk_next_words", rx_n - b_rx, 1);
        expect_word("brk_next", 8'h5A, 1'b0, 1'b0);

        // Glitch of 3 ticks is rejected as a false start
        b_brk = brk_n; b_valid = valid_n; b_ovr = ovr_n;
        rx = 1'b0;
        cyc(3 * (int'(baud) + 1));
        rx = 1'b1;
        wait_bits(12);
        check("glitch_valid", valid_n - b_valid, 0);
        check("glitch_brk", brk_n - b_brk, 0);
        check("glitch_ovr", ovr_n - b_ovr, 0);

        // Framing error on a non-zero word, then recovery
        b_rx = rx_n; b_brk = brk_n;
        send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        wait_bits(1);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("ferr_words", rx_n - b_rx, 2);
        check("ferr_no_brk", brk_n - b_brk, 0);
        expect_word("ferr", 8'h0F, 1'b1, 1'b0);
        expect_word("ferr_next", 8'h3C, 1'b0, 1'b0);

        // Even parity instance: 0x31 has three ones, so the correct parity bit is 1
        b_prx = p_rx_n;
        send(1'b1, 8'h31, 1'b1, 1'b0, 1'b1);
        wait_bits(1);
        send(1'b1, 8'h31, 1'b1, 1'b1, 1'b1);
        wait_bits(2);
        check("par_words", p_rx_n - b_prx, 2);
        expect_pword("par_bad", 8'h31, 1'b1);
        expect_pword("par_good", 8'h31, 1'b0);

        // Reset mid-frame while a word is held
        ready = 1'b0;
        send(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        wait_bits(1);
        check("mid_pre_valid", valid, 1'b1);
        rx = 1'b0; wait_bits(1);
        rx = 1'b1; wait_bits(1);
        rx = 1'b0; wait_bits(1);
        rx = 1'b1; wait_bits(1);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        ready = 1'b1;
        cyc(1);
        check("mid_valid", valid, 1'b0);
        check("mid_data", data, 8'h00);
        check("mid_rts", rts, 1'b1);
        check("mid_fe", fe, 1'b0);
        b_rx = rx_n; b_brk = brk_n;
        wait_bits(12);
        check("mid_no_words", rx_n - b_rx, 0);
        check("mid_no_brk", brk_n - b_brk, 0);
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_bits(2);
        check("mid_next_words", rx_n - b_rx, 1);
        expect_word("mid_next", 8'h55, 1'b0, 1'b0);

        // Invariants over the whole run
        check("rts_tracks_valid", rts_bad_n, 0);
        check("par_rts_tracks_valid", p_rts_bad_n, 0);
        check("par_no_brk_ovr", p_evt_n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
